// File: rtl/delay_mc.sv
// delay_mc: multi-channel echo/delay with feedback and dry/wet blend.
// Every channel owns a circular buffer inside one shared single-port RAM
// addressed as {channel, pointer}. The delay length ramps by one frame per
// accepted frame toward the requested value so that delay changes do not
// produce audible clicks.

module delay_mc #(
   parameter int SIG_BITS = 16,
   parameter int CH       = 2,
   parameter int DLY_B    = 13,
   parameter int FDB_B    = 10,
   parameter int BLEND_B  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [CH*SIG_BITS-1:0] in,
   input  logic [DLY_B-1:0]       delay,
   input  logic [FDB_B-1:0]       feedbk,
   input  logic [BLEND_B-1:0]     blend,
   output logic [CH*SIG_BITS-1:0] out,
   output logic                   out_valid,
   output logic                   busy,
   output logic                   overrun
);

   localparam int CHB   = (CH > 1) ? $clog2(CH) : 1;
   localparam int AW    = CHB + DLY_B;
   localparam int DEPTH = CH * (2 ** DLY_B);
   localparam int MIX_W = SIG_BITS + BLEND_B + 2;
   localparam int FB_W  = SIG_BITS + FDB_B + 2;

   localparam logic [AW-1:0]  CLR_LAST = AW'(DEPTH - 1);
   localparam logic [CHB-1:0] CH_LAST  = CHB'(CH - 1);

   localparam logic signed [FB_W-1:0] SAT_MAX =
      {{(FB_W-SIG_BITS+1){1'b0}}, {(SIG_BITS-1){1'b1}}};
   localparam logic signed [FB_W-1:0] SAT_MIN =
      {{(FB_W-SIG_BITS+1){1'b1}}, {(SIG_BITS-1){1'b0}}};

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_RD,
      S_WAIT,
      S_CALC,
      S_WR
   } state_t;

   state_t                 state;
   logic [AW-1:0]          addr;
   logic [DLY_B-1:0]       wr_ptr;
   logic [DLY_B-1:0]       cur_dly;
   logic [CHB-1:0]         ch_idx;
   logic [CH*SIG_BITS-1:0] x_frame;
   logic [CH*SIG_BITS-1:0] o_frame;
   logic [SIG_BITS-1:0]    w_reg;

   logic [SIG_BITS-1:0]    mem [DEPTH];
   logic [SIG_BITS-1:0]    q;
   logic                   ram_we;
   logic [SIG_BITS-1:0]    ram_wdata;

   logic [DLY_B-1:0]       tgt;
   logic signed [SIG_BITS-1:0] x_cur;
   logic signed [MIX_W-1:0]    x_mix;
   logic signed [MIX_W-1:0]    d_mix;
   logic signed [MIX_W-1:0]    blend_ext;
   logic signed [MIX_W-1:0]    mix_prod;
   logic signed [MIX_W-1:0]    mix_sum;
   logic signed [FB_W-1:0]     x_fb;
   logic signed [FB_W-1:0]     d_fb;
   logic signed [FB_W-1:0]     fdb_ext;
   logic signed [FB_W-1:0]     fb_prod;
   logic signed [FB_W-1:0]     fb_sum;
   logic [SIG_BITS-1:0]        o_val;
   logic [SIG_BITS-1:0]        w_val;

   // A requested delay of zero would read the slot being written, so it is treated as one
   assign tgt = (delay == '0) ? DLY_B'(1) : delay;

   // The RAM is written while clearing and during each channel's write-back slot
   assign ram_we    = (state == S_CLEAR) || (state == S_WR);
   assign ram_wdata = (state == S_CLEAR) ? '0 : w_reg;

   // Single-port buffer RAM with one cycle of read latency
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[addr] <= ram_wdata;
      end
      q <= mem[addr];
   end

   // Wet/dry interpolation and saturating feedback for the channel being processed
   always_comb begin
      x_cur     = x_frame[int'(ch_idx)*SIG_BITS +: SIG_BITS];
      x_mix     = {{(MIX_W-SIG_BITS){x_cur[SIG_BITS-1]}}, x_cur};
      d_mix     = {{(MIX_W-SIG_BITS){q[SIG_BITS-1]}}, q};
      blend_ext = {{(MIX_W-BLEND_B){1'b0}}, blend};
      mix_prod  = (d_mix - x_mix) * blend_ext;
      mix_sum   = x_mix + (mix_prod >>> BLEND_B);
      o_val     = mix_sum[SIG_BITS-1:0];

      x_fb      = {{(FB_W-SIG_BITS){x_cur[SIG_BITS-1]}}, x_cur};
      d_fb      = {{(FB_W-SIG_BITS){q[SIG_BITS-1]}}, q};
      fdb_ext   = {{(FB_W-FDB_B){1'b0}}, feedbk};
      fb_prod   = d_fb * fdb_ext;
      fb_sum    = x_fb + (fb_prod >>> FDB_B);
      if (fb_sum > SAT_MAX) begin
         w_val = SAT_MAX[SIG_BITS-1:0];
      end else if (fb_sum < SAT_MIN) begin
         w_val = SAT_MIN[SIG_BITS-1:0];
      end else begin
         w_val = fb_sum[SIG_BITS-1:0];
      end
   end

   // Control FSM: clear the RAM, then run four slots per channel for each accepted frame
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_CLEAR;
         addr      <= '0;
         wr_ptr    <= '0;
         cur_dly   <= DLY_B'(1);
         ch_idx    <= '0;
         x_frame   <= '0;
         o_frame   <= '0;
         w_reg     <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b1;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid && busy) begin
            overrun <= 1'b1;
         end
         case (state)
            S_CLEAR: begin
               addr <= addr + AW'(1);
               if (addr == CLR_LAST) begin
                  addr  <= '0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (in_valid) begin
                  x_frame <= in;
                  if (cur_dly < tgt) begin
                     cur_dly <= cur_dly + DLY_B'(1);
                  end else if (cur_dly > tgt) begin
                     cur_dly <= cur_dly - DLY_B'(1);
                  end
                  ch_idx <= '0;
                  busy   <= 1'b1;
                  state  <= S_RD;
               end
            end
            S_RD: begin
               addr  <= {ch_idx, wr_ptr - cur_dly};
               state <= S_WAIT;
            end
            S_WAIT: begin
               state <= S_CALC;
            end
            S_CALC: begin
               o_frame[int'(ch_idx)*SIG_BITS +: SIG_BITS] <= o_val;
               w_reg <= w_val;
               addr  <= {ch_idx, wr_ptr};
               state <= S_WR;
            end
            S_WR: begin
               if (ch_idx == CH_LAST) begin
                  out       <= o_frame;
                  out_valid <= 1'b1;
                  wr_ptr    <= wr_ptr + DLY_B'(1);
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end else begin
                  ch_idx <= ch_idx + CHB'(1);
                  state  <= S_RD;
               end
            end
            default: begin
               state <= S_CLEAR;
            end
         endcase
      end
   end

endmodule
